matrix_loader: RTL



---
 rtl/matrix_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/matrix_loader.sv
// Streams matrix A then matrix B into the banked A/B BRAM write ports, then
// requests a multiply from the controller and waits for it to finish.
module matrix_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned M          = 3,
  parameter int unsigned K          = 3,
  parameter int unsigned N          = 3,
  parameter int unsigned N_BANKS    = 3,
  localparam int unsigned AW_A = (M / N_BANKS * K > 1) ? $clog2(M / N_BANKS * K) : 1,
  localparam int unsigned AW_B = (K * N / N_BANKS > 1) ? $clog2(K * N / N_BANKS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [N_BANKS-1:0]            en_a_brams_in,
  output logic [N_BANKS-1:0]            we_a_brams_in,
  output logic [N_BANKS*AW_A-1:0]       addr_a_brams_in,
  output logic [N_BANKS*DATA_WIDTH-1:0] din_a_brams_in,
  output logic [N_BANKS-1:0]            en_b_brams_in,
  output logic [N_BANKS-1:0]            we_b_brams_in,
  output logic [N_BANKS*AW_B-1:0]       addr_b_brams_in,
  output logic [N_BANKS*DATA_WIDTH-1:0] din_b_brams_in,
  output logic                          start_mult,
  input  logic                          mult_done,
  output logic                          load_busy,
  output logic                          done_pulse
);

  localparam int unsigned A_GRPS = M / N_BANKS;
  localparam int unsigned B_GRPS = N / N_BANKS;
  localparam int unsigned BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int unsigned AGRP_W = (A_GRPS > 1) ? $clog2(A_GRPS) : 1;
  localparam int unsigned BGRP_W = (B_GRPS > 1) ? $clog2(B_GRPS) : 1;
  localparam int unsigned K_W    = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  if ((M % N_BANKS) != 0 || (N % N_BANKS) != 0) begin : g_bad_cfg
    $error("matrix_loader: M and N must be integer multiples of N_BANKS");
  end

  logic [2:0]                    state_q, state_d;
  logic                          beat, a_last, b_last;
  logic [AW_A-1:0]               a_addr;
  logic [AW_B-1:0]               b_addr;

  // A walks (bank = r%N_BANKS, grp = r/N_BANKS, col k); B walks (row k, bank = j%N_BANKS, grp = j/N_BANKS)
  logic [BANK_W-1:0]             a_bank_q, b_bank_q;
  logic [AGRP_W-1:0]             a_grp_q;
  logic [BGRP_W-1:0]             b_grp_q;
  logic [K_W-1:0]                a_col_q, b_row_q;

  logic                          s_ready_q, start_mult_q, load_busy_q, done_pulse_q;
  logic [N_BANKS-1:0]            en_a_q, en_a_d, en_b_q, en_b_d;
  logic [N_BANKS*AW_A-1:0]       addr_a_q, addr_a_d;
  logic [N_BANKS*AW_B-1:0]       addr_b_q, addr_b_d;
  logic [N_BANKS*DATA_WIDTH-1:0] din_a_q, din_a_d, din_b_q, din_b_d;

  assign beat   = s_valid && s_ready_q;
  assign a_last = (a_col_q == K_W'(K - 1)) && (a_bank_q == BANK_W'(N_BANKS - 1)) &&
                  (a_grp_q == AGRP_W'(A_GRPS - 1));
  assign b_last = (b_row_q == K_W'(K - 1)) && (b_bank_q == BANK_W'(N_BANKS - 1)) &&
                  (b_grp_q == BGRP_W'(B_GRPS - 1));
  assign a_addr = AW_A'(int'(a_grp_q) * int'(K) + int'(a_col_q));
  assign b_addr = AW_B'(int'(b_row_q) * int'(B_GRPS) + int'(b_grp_q));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load_start)       state_d = S_LOAD_A;
      S_LOAD_A: if (beat && a_last)   state_d = S_LOAD_B;
      S_LOAD_B: if (beat && b_last)   state_d = S_FLUSH;
      S_FLUSH:                        state_d = S_RUN;
      S_RUN:    if (mult_done)        state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Write-port payload for the beat accepted on this edge; idle banks stay all-zero
  always_comb begin
    en_a_d   = '0;
    addr_a_d = '0;
    din_a_d  = '0;
    en_b_d   = '0;
    addr_b_d = '0;
    din_b_d  = '0;
    for (int b = 0; b < int'(N_BANKS); b++) begin
      if (state_q == S_LOAD_A && beat && a_bank_q == BANK_W'(b)) begin
        en_a_d[b]                           = 1'b1;
        addr_a_d[b*AW_A +: AW_A]             = a_addr;
        din_a_d[b*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      if (state_q == S_LOAD_B && beat && b_bank_q == BANK_W'(b)) begin
        en_b_d[b]                           = 1'b1;
        addr_b_d[b*AW_B +: AW_B]             = b_addr;
        din_b_d[b*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
    end
  end

  // Element counters, cleared on entry to each load phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_bank_q <= '0;
      a_grp_q  <= '0;
      a_col_q  <= '0;
      b_row_q  <= '0;
      b_bank_q <= '0;
      b_grp_q  <= '0;
    end else begin
      if (state_q == S_IDLE && state_d == S_LOAD_A) begin
        a_bank_q <= '0;
        a_grp_q  <= '0;
        a_col_q  <= '0;
      end else if (state_q == S_LOAD_A && beat) begin
        if (a_col_q == K_W'(K - 1)) begin
          a_col_q <= '0;
          if (a_bank_q == BANK_W'(N_BANKS - 1)) begin
            a_bank_q <= '0;
            a_grp_q  <= a_grp_q + AGRP_W'(1);
          end else begin
            a_bank_q <= a_bank_q + BANK_W'(1);
          end
        end else begin
          a_col_q <= a_col_q + K_W'(1);
        end
      end

      if (state_q == S_LOAD_A && state_d == S_LOAD_B) begin
        b_row_q  <= '0;
        b_bank_q <= '0;
        b_grp_q  <= '0;
      end else if (state_q == S_LOAD_B && beat) begin
        if (b_bank_q == BANK_W'(N_BANKS - 1)) begin
          b_bank_q <= '0;
          if (b_grp_q == BGRP_W'(B_GRPS - 1)) begin
            b_grp_q <= '0;
            b_row_q <= b_row_q + K_W'(1);
          end else begin
            b_grp_q <= b_grp_q + BGRP_W'(1);
          end
        end else begin
          b_bank_q <= b_bank_q + BANK_W'(1);
        end
      end
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready_q    <= 1'b0;
      start_mult_q <= 1'b0;
      load_busy_q  <= 1'b0;
      done_pulse_q <= 1'b0;
      en_a_q       <= '0;
      addr_a_q     <= '0;
      din_a_q      <= '0;
      en_b_q       <= '0;
      addr_b_q     <= '0;
      din_b_q      <= '0;
    end else begin
      s_ready_q    <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
      start_mult_q <= (state_d == S_RUN);
      load_busy_q  <= (state_d != S_IDLE);
      done_pulse_q <= (state_q == S_RUN) && mult_done;
      en_a_q       <= en_a_d;
      addr_a_q     <= addr_a_d;
      din_a_q      <= din_a_d;
      en_b_q       <= en_b_d;
      addr_b_q     <= addr_b_d;
      din_b_q      <= din_b_d;
    end
  end

  assign s_ready         = s_ready_q;
  assign start_mult      = start_mult_q;
  assign load_busy       = load_busy_q;
  assign done_pulse      = done_pulse_q;
  assign en_a_brams_in   = en_a_q;
  assign we_a_brams_in   = en_a_q;
  assign addr_a_brams_in = addr_a_q;
  assign din_a_brams_in  = din_a_q;
  assign en_b_brams_in   = en_b_q;
  assign we_b_brams_in   = en_b_q;
  assign addr_b_brams_in = addr_b_q;
  assign din_b_brams_in  = din_b_q;

endmodule
